// File: rtl/seg_scan_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_pkg
//
// Shared definitions for the seg_scan display scanner:
//   ANODE_OFF            - all anodes released (active-low, so all ones),
//                          sized for the largest supported digit count
//   DP_OFF               - decimal point dark (active low)
//   DEFAULT_REFRESH_DIV  - default number of clocks each digit is held
//   MAX_DIGITS           - upper bound on NUM_DIGITS
//   clog2()              - index / counter width helper, never below 1
// ---------------------------------------------------------------------------
package seg_scan_pkg;

    localparam int MAX_DIGITS          = 8;
    localparam int DEFAULT_REFRESH_DIV = 100000;

    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;
    localparam logic                  DP_OFF    = 1'b1;

    // Bits needed to hold the values 0..value-1. A width of zero is never
    // useful for a register, so the result is clamped to at least 1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage : seg_scan_pkg

// File: rtl/seg_tick_gen.sv
// ---------------------------------------------------------------------------
// seg_tick_gen
//
// Free-running prescaler for the display scanner. Counts 0..REFRESH_DIV-1
// and raises tick for the single cycle the count sits at its terminal value;
// the count returns to 0 on the following edge.
//
// Parameters:
//   REFRESH_DIV  clock cycles per tick period (minimum 2)
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous, active-high reset (count cleared to 0)
//   tick  out  one-cycle pulse at terminal count
// ---------------------------------------------------------------------------
import seg_scan_pkg::*;

module seg_tick_gen #(
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int               CNT_W    = clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // tick is decoded straight from the count so that the scan index and the
    // commit logic see it in the same cycle the count reaches its end.
    assign tick = (cnt == TERMINAL);

    // NOTE: sequential state is always updated with non-blocking assignments
    // so every register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule : seg_tick_gen

// File: rtl/seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan
//
// Time-multiplexed scanner for an N-digit common-anode 7-segment display.
// Each scan slot presents one 4-bit digit value to the downstream nibble to
// segment decoder together with the matching active-low anode and decimal
// point. The displayed value is double-buffered: load captures into a
// staging register, and staging is copied to the display register only on
// the tick that wraps the scan index back to digit 0, so a frame never
// mixes old and new digits.
//
// Optional feature (compile-time macro SEG_SCAN_LZ_BLANK_EN):
//   leading-zero blanking. Digit i > 0 is dark when display nibbles
//   i..NUM_DIGITS-1 are all zero; digit 0 is never blanked. Without the
//   macro every enabled digit is lit.
//
// Parameters:
//   NUM_DIGITS   digits scanned, 2..8
//   REFRESH_DIV  clock cycles each digit is held, minimum 2
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous, active-high reset
//   value_in      in   packed nibbles, digit 0 in bits [3:0]
//   dp_in         in   decimal point request per digit, 1 = lit
//   load          in   single-cycle strobe capturing value_in / dp_in
//   digit_en      in   per-digit enable, sampled live every slot
//   bnum          out  nibble of the current digit, to the decoder
//   an            out  anode enables, active low, at most one bit low
//   dp            out  decimal point, active low
//   load_pending  out  a staged value is waiting for the next frame
//   frame_start   out  one-cycle pulse after the index wraps to 0
// ---------------------------------------------------------------------------
import seg_scan_pkg::*;

module seg_scan #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [3:0]              bnum,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    load_pending,
    output logic                    frame_start
);

    localparam int                    IDX_W    = clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = ANODE_OFF[NUM_DIGITS-1:0];

    logic                        tick;
    logic                        wrap_tick;
    logic [IDX_W-1:0]            idx;

    logic [NUM_DIGITS-1:0][3:0]  stage_val;
    logic [NUM_DIGITS-1:0]       stage_dp;
    logic [NUM_DIGITS-1:0][3:0]  disp_val;
    logic [NUM_DIGITS-1:0]       disp_dp;

    logic                        cur_blank;
    logic                        cur_lit;
    logic [3:0]                  bnum_next;
    logic [NUM_DIGITS-1:0]       an_next;
    logic                        dp_next;

    // -----------------------------------------------------------------------
    // Slot timing
    // -----------------------------------------------------------------------
    seg_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // The tick that ends the last slot is the frame boundary: it wraps the
    // index, commits staged data and schedules frame_start.
    assign wrap_tick = tick && (idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (wrap_tick) begin
            idx <= '0;
        end else if (tick) begin
            idx <= idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap_tick;
        end
    end

    // -----------------------------------------------------------------------
    // Double buffer
    // -----------------------------------------------------------------------
    // A load arriving on the commit tick wins over the clear of load_pending:
    // the old staging content is committed on this edge while the new data
    // lands in staging and waits for the following frame.
    // NOTE: staging and display are plain registers, not memories, so they
    // are reset; a freshly reset display shows zeros instead of X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_val    <= '0;
            stage_dp     <= '0;
            load_pending <= 1'b0;
        end else if (load) begin
            stage_val    <= value_in;
            stage_dp     <= dp_in;
            load_pending <= 1'b1;
        end else if (wrap_tick) begin
            load_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_val <= '0;
            disp_dp  <= '0;
        end else if (wrap_tick && load_pending) begin
            disp_val <= stage_val;
            disp_dp  <= stage_dp;
        end
    end

    // -----------------------------------------------------------------------
    // Leading-zero blanking
    // -----------------------------------------------------------------------
`ifdef SEG_SCAN_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] blank;

    // Walk from the most significant digit down; a digit is blanked while
    // it and everything above it are zero. Digit 0 is excluded so a zero
    // value still shows a single '0'.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank      = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero && (disp_val[i] == 4'd0);
            blank[i]   = upper_zero;
        end
    end

    assign cur_blank = blank[idx];
`else
    assign cur_blank = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Output stage
    // -----------------------------------------------------------------------
    assign cur_lit = digit_en[idx] && !cur_blank;

    // NOTE: every signal written here gets its default before any condition,
    // so no path leaves a value held and no latch is inferred.
    always_comb begin
        bnum_next = disp_val[idx];
        an_next   = AN_OFF;
        dp_next   = DP_OFF;
        if (cur_lit) begin
            an_next[idx] = 1'b0;
            dp_next      = ~disp_dp[idx];
        end
    end

    // Outputs are registered so the decoder and pad drivers see clean,
    // glitch-free levels; this adds one cycle between idx and the anodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bnum <= 4'd0;
            an   <= AN_OFF;
            dp   <= DP_OFF;
        end else begin
            bnum <= bnum_next;
            an   <= an_next;
            dp   <= dp_next;
        end
    end

endmodule : seg_scan

// File: tb/tb_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_seg_scan
//
// Bench for seg_scan with NUM_DIGITS=4, REFRESH_DIV=4. Honours the
// SEG_SCAN_LZ_BLANK_EN macro so it matches whichever build is compiled.
// The reference model tracks time as a plain cycle count: slot and digit
// follow from integer division, display/staging are whole 16-bit words.
// ---------------------------------------------------------------------------
module tb_seg_scan;

    localparam int N   = 4;
    localparam int DIV = 4;

    typedef struct packed {
        logic [3:0] bnum;
        logic [3:0] an;
        logic       dp;
        logic       lp;
        logic       fs;
    } obs_t;

    logic          clk;
    logic          rst;
    logic [15:0]   value_in;
    logic [3:0]    dp_in;
    logic          load;
    logic [3:0]    digit_en;
    logic [3:0]    bnum;
    logic [3:0]    an;
    logic          dp;
    logic          load_pending;
    logic          frame_start;

    int checks = 0;
    int errors = 0;

    obs_t exp_q[$];

    // Reference model state
    int          m_c;        // rising edges since reset release
    logic [15:0] m_stage_v;
    logic [3:0]  m_stage_d;
    logic [15:0] m_disp_v;
    logic [3:0]  m_disp_d;
    logic        m_pend;
    logic [3:0]  cur_en;

    seg_scan #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .value_in     (value_in),
        .dp_in        (dp_in),
        .load         (load),
        .digit_en     (digit_en),
        .bnum         (bnum),
        .an           (an),
        .dp           (dp),
        .load_pending (load_pending),
        .frame_start  (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int model_idx();
        return (m_c / DIV) % N;
    endfunction

    function automatic logic next_is_wrap();
        return ((m_c % DIV) == DIV - 1) && (model_idx() == N - 1);
    endfunction

    function automatic logic blanked(input int i);
`ifdef SEG_SCAN_LZ_BLANK_EN
        return (i > 0) && ((m_disp_v >> (4 * i)) == 16'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_c       = 0;
        m_stage_v = '0;
        m_stage_d = '0;
        m_disp_v  = '0;
        m_disp_d  = '0;
        m_pend    = 1'b0;
    endtask

    // Predict the outputs after the coming rising edge from the inputs now
    // on the pins, then advance the model by one cycle.
    task automatic model_edge();
        obs_t e;
        int   i;
        logic wrap;
        logic lit;
        i    = model_idx();
        wrap = next_is_wrap();
        lit  = digit_en[i] && !blanked(i);
        e.bnum = 4'((m_disp_v >> (4 * i)) & 16'hF);
        e.an   = lit ? ~(4'b0001 << i) : 4'b1111;
        e.dp   = lit ? ~m_disp_d[i] : 1'b1;
        e.fs   = wrap;
        if (wrap && m_pend) begin
            m_disp_v = m_stage_v;
            m_disp_d = m_stage_d;
        end
        if (load) begin
            m_stage_v = value_in;
            m_stage_d = dp_in;
            m_pend    = 1'b1;
        end else if (wrap) begin
            m_pend = 1'b0;
        end
        e.lp = m_pend;
        exp_q.push_back(e);
        m_c++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d);
        @(negedge clk);
        load     = ld;
        value_in = ld ? v : 16'($urandom);   // ignored unless loading
        dp_in    = ld ? d : 4'($urandom);
        digit_en = cur_en;
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 16'h0, 4'h0);
    endtask

    task automatic run_until_wrap();
        while (!next_is_wrap()) idle(1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst      = 1'b0;
        load     = 1'b0;
        digit_en = cur_en;
        model_reset();
        model_edge();
    endtask

    // ---------------- monitor ----------------
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{bnum: bnum, an: an, dp: dp, lp: load_pending, fs: frame_start};
                check("cycle_outputs", 32'(a), 32'(e));
                check("single_anode", 32'($countones(~an) <= 1), 32'd1);
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst      = 1'b0;
        load     = 1'b0;
        value_in = '0;
        dp_in    = '0;
        cur_en   = 4'b1111;
        digit_en = cur_en;
        model_reset();

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        check("reset_an",   32'(an), 32'hF);
        check("reset_bnum", 32'(bnum), 32'h0);
        check("reset_dp",   32'(dp), 32'h1);
        check("reset_lp",   32'(load_pending), 32'h0);
        check("reset_fs",   32'(frame_start), 32'h0);
        release_reset();

        // Scan order and frame pulse
        step(1'b1, 16'h1234, 4'h0);
        idle(40);

        // Mid-frame load while idx = 1
        while (model_idx() != 1) idle(1);
        step(1'b1, 16'hABCD, 4'h0);
        idle(40);

        // Two loads inside one frame: only the second is ever shown
        run_until_wrap();
        idle(1);
        step(1'b1, 16'h1111, 4'h0);
        idle(2);
        step(1'b1, 16'h2222, 4'h0);
        idle(40);

        // Load coinciding with the commit tick
        run_until_wrap();
        idle(1);
        step(1'b1, 16'h5555, 4'h0);
        run_until_wrap();
        step(1'b1, 16'h6666, 4'h0);
        idle(40);

        // Enables and decimal points
        cur_en = 4'b0101;
        step(1'b1, 16'h89AB, 4'b0100);
        idle(40);
        cur_en = 4'b1111;

        // Leading-zero candidate value
        step(1'b1, 16'h0070, 4'h0);
        idle(40);
        step(1'b1, 16'h0000, 4'b0001);
        idle(40);

        // Reset mid-scan with data pending and digit 2 on display
        step(1'b1, 16'h4321, 4'b0110);
        idle(40);
        run_until_wrap();
        idle(1);
        step(1'b1, 16'h9876, 4'h0);
        while (model_idx() != 2) idle(1);
        idle(1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midscan_an",   32'(an), 32'hF);
        check("midscan_bnum", 32'(bnum), 32'h0);
        check("midscan_dp",   32'(dp), 32'h1);
        check("midscan_lp",   32'(load_pending), 32'h0);
        @(negedge clk);
        release_reset();
        idle(40);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(7) == 0) cur_en = 4'($urandom);
            if ($urandom_range(5) == 0)
                step(1'b1, 16'($urandom), 4'($urandom));
            else
                idle(1);
        end
        idle(4);

        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seg_scan
